// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the block-RAM controller slice.
// Tag index is sized for the widest supported requester count so rd_tag_t is one shared type.
package ram_ctrl_pkg;
  localparam int N_REQ_MAX = 8;
  localparam int REQ_IDX_W = $clog2(N_REQ_MAX);
  localparam int RAM_RD_LAT_OREG = 2;
  localparam int RAM_RD_LAT_NOREG = 1;

  typedef struct packed {
    logic                 valid;
    logic [REQ_IDX_W-1:0] idx;
  } rd_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Generic combinational round-robin arbiter: search starts one past 'last' and wraps.
// Zero latency; grant is all-zero when 'en' is low or nothing requests.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end
endmodule

// File: rtl/ram_rd_arbiter.sv
// Round-robin sharing of the block-RAM read port; one read per cycle, data returned RD_LATENCY
// cycles after the grant to the issuing requester. Responses carry no backpressure.
module ram_rd_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = RAM_RD_LAT_OREG
) (
  input  logic                        rd_clk,
  input  logic                        rd_rst,
  input  logic                        arb_en,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]       resp_data,
  output logic [ADDR_WIDTH-1:0]       ram_rd_addr,
  output logic                        ram_rd_clk_en,
  output logic                        ram_rd_oce,
  input  logic [DATA_WIDTH-1:0]       ram_rd_data
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]      grant;
  logic [IW-1:0]         grant_idx;
  logic [IW-1:0]         last_grant;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] addr_q;
  rd_tag_t               tag [RD_LATENCY];
  logic                  tag_any;

  // Reset gates the enable so no grant is visible while the block is held in reset.
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid),
    .en    (arb_en & ~rd_rst),
    .last  (last_grant),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign grant_any   = |grant;
  assign req_ready   = grant;
  assign ram_rd_addr = grant_any ? req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : addr_q;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      last_grant <= IW'(N_REQ-1);
      addr_q     <= '0;
      for (int s = 0; s < RD_LATENCY; s++) tag[s] <= '0;
    end else begin
      if (grant_any) begin
        last_grant <= grant_idx;
        addr_q     <= ram_rd_addr;
      end
      tag[0] <= '{valid: grant_any, idx: REQ_IDX_W'(grant_idx)};
      for (int s = 1; s < RD_LATENCY; s++) tag[s] <= tag[s-1];
    end
  end

  always_comb begin
    tag_any = 1'b0;
    for (int s = 0; s < RD_LATENCY; s++) tag_any = tag_any | tag[s].valid;
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < N_REQ; i++)
      resp_valid[i] = tag[RD_LATENCY-1].valid && (tag[RD_LATENCY-1].idx == REQ_IDX_W'(i));
  end

  assign resp_data     = ram_rd_data;
  assign ram_rd_clk_en = grant_any | tag_any;
  // The output register only needs to advance in the cycle after a real read was sampled.
  assign ram_rd_oce    = (RD_LATENCY == RAM_RD_LAT_OREG) ? tag[0].valid : 1'b0;
endmodule
